// File: rtl/exc_pkg.sv
// Shared cause codes, FSM state type and priority encoder for the exception request controller.
package exc_pkg;

    localparam logic [3:0] EXC_NONE  = 4'b0000;
    localparam logic [3:0] EXC_INVOP = 4'b0001;
    localparam logic [3:0] EXC_IRQ   = 4'b0010;
    localparam logic [3:0] EXC_TIMER = 4'b0011;

    // Bit positions inside the pending register.
    localparam int PEND_INVOP = 0;
    localparam int PEND_TIMER = 1;
    localparam int PEND_IRQ   = 2;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HANDLER
    } exc_state_t;

    function automatic logic [3:0] cause_sel(input logic [2:0] pend);
        if (pend[PEND_INVOP])      return EXC_INVOP;
        else if (pend[PEND_TIMER]) return EXC_TIMER;
        else if (pend[PEND_IRQ])   return EXC_IRQ;
        else                       return EXC_NONE;
    endfunction

    // Maps a cause code back to its one-hot pending bit.
    function automatic logic [2:0] cause_mask(input logic [3:0] cause);
        case (cause)
            EXC_INVOP: return 3'b001;
            EXC_TIMER: return 3'b010;
            EXC_IRQ:   return 3'b100;
            default:   return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/exc_timer.sv
// Free-running periodic tick source: one-cycle pulse every PERIOD clocks.
module exc_timer #(
    parameter int PERIOD = 1000
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int             CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0]  RELOAD = CW'(PERIOD - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= RELOAD;
        else       cnt_q <= cnt_d;
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/exc_request_ctrl.sv
// Exception request initiator: pends sources, raises Exc with cause/vector until ExcAck, blocks until Eret.
// Optional periodic timer source enabled by defining EXC_TIMER_EN.
module exc_request_ctrl
    import exc_pkg::*;
#(
    parameter logic [63:0] VEC_BASE        = 64'h0000_0000_0000_D800,
    parameter int          VEC_STRIDE_LOG2 = 7,
    parameter int          TIMER_PERIOD    = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        invalid_op,
    input  logic        irq_ext,
    input  logic        ExcAck,
    input  logic        Eret,
    output logic        Exc,
    output logic [3:0]  EStatus,
    output logic [63:0] Exc_vector,
    output logic        in_handler
);

    logic timer_src;

`ifdef EXC_TIMER_EN
    localparam logic [2:0] PEND_MASK = 3'b111;

    exc_timer #(
        .PERIOD (TIMER_PERIOD)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .tick  (timer_src)
    );
`else
    localparam logic [2:0] PEND_MASK = 3'b101;

    assign timer_src = 1'b0;
`endif

    exc_state_t  state_q, state_d;
    logic [2:0]  pend_q, pend_d;
    logic        exc_q, exc_d;
    logic [3:0]  est_q, est_d;
    logic [63:0] vec_q, vec_d;
    logic        inh_q, inh_d;
    logic [2:0]  src;
    logic [2:0]  clr;

    function automatic logic [63:0] vec_of(input logic [3:0] cause);
        return VEC_BASE + (64'(cause) << VEC_STRIDE_LOG2);
    endfunction

    assign src = {irq_ext, timer_src, invalid_op};

    always_comb begin
        state_d = state_q;
        exc_d   = exc_q;
        est_d   = est_q;
        vec_d   = vec_q;
        inh_d   = inh_q;
        clr     = 3'b000;

        case (state_q)
            IDLE: begin
                // Live inputs are included so Exc rises on the very edge that samples the pulse.
                if ((pend_q | src) != 3'b000) begin
                    state_d = REQ;
                    exc_d   = 1'b1;
                    est_d   = cause_sel(pend_q | src);
                    vec_d   = vec_of(est_d);
                end
            end
            REQ: begin
                if (ExcAck) begin
                    clr     = cause_mask(est_q);
                    exc_d   = 1'b0;
                    inh_d   = 1'b1;
                    state_d = HANDLER;
                end
            end
            HANDLER: begin
                if (Eret) begin
                    inh_d   = 1'b0;
                    est_d   = EXC_NONE;
                    vec_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A source sampled on the acknowledge edge survives the clear.
        pend_d = ((pend_q & ~clr) | src) & PEND_MASK;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pend_q  <= 3'b000;
            exc_q   <= 1'b0;
            est_q   <= EXC_NONE;
            vec_q   <= '0;
            inh_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            exc_q   <= exc_d;
            est_q   <= est_d;
            vec_q   <= vec_d;
            inh_q   <= inh_d;
        end
    end

    assign Exc        = exc_q;
    assign EStatus    = est_q;
    assign Exc_vector = vec_q;
    assign in_handler = inh_q;

endmodule

// File: tb/tb_exc_request_ctrl.sv
// Self-checking bench for exc_request_ctrl against a behavioural model of the exception handshake.
module tb_exc_request_ctrl;

    localparam logic [63:0] VB = 64'h0000_0000_0000_D800;
    localparam int          SL = 7;
    localparam int          TP = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        invalid_op = 1'b0;
    logic        irq_ext = 1'b0;
    logic        ExcAck = 1'b0;
    logic        Eret = 1'b0;
    logic        Exc;
    logic [3:0]  EStatus;
    logic [63:0] Exc_vector;
    logic        in_handler;
    logic [69:0] obs;

    int vectors = 0;
    int miscompares = 0;

    // Model state: pending flags indexed by cause code, request/handler flags, latched cause.
    bit         m_pend [4];
    bit         m_exc;
    bit         m_inh;
    logic [3:0] m_est;
    int         m_tcnt;

    exc_request_ctrl #(
        .VEC_BASE        (VB),
        .VEC_STRIDE_LOG2 (SL),
        .TIMER_PERIOD    (TP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .invalid_op (invalid_op),
        .irq_ext    (irq_ext),
        .ExcAck     (ExcAck),
        .Eret       (Eret),
        .Exc        (Exc),
        .EStatus    (EStatus),
        .Exc_vector (Exc_vector),
        .in_handler (in_handler)
    );

    always #5 clk = ~clk;

    assign obs = {Exc, EStatus, Exc_vector, in_handler};

    function automatic logic [69:0] expected();
        logic [63:0] v;
        v = (m_est == 4'd0) ? 64'd0 : VB + 64'(m_est) * (64'd1 << SL);
        return {m_exc, m_est, v, m_inh};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
        m_exc  = 1'b0;
        m_inh  = 1'b0;
        m_est  = 4'd0;
        m_tcnt = 0;
    endtask

    task automatic model_step(input bit io, input bit irq, input bit ack, input bit eret);
        bit tick;
        tick = 1'b0;
`ifdef EXC_TIMER_EN
        tick = ((m_tcnt % TP) == TP - 1);
`endif
        m_tcnt++;
        if (!m_exc && !m_inh) begin
            if (m_pend[1] || io)        begin m_exc = 1'b1; m_est = 4'd1; end
            else if (m_pend[3] || tick) begin m_exc = 1'b1; m_est = 4'd3; end
            else if (m_pend[2] || irq)  begin m_exc = 1'b1; m_est = 4'd2; end
        end else if (m_exc) begin
            if (ack) begin
                m_pend[m_est] = 1'b0;
                m_exc = 1'b0;
                m_inh = 1'b1;
            end
        end else if (eret) begin
            m_inh = 1'b0;
            m_est = 4'd0;
        end
        if (io)   m_pend[1] = 1'b1;
        if (irq)  m_pend[2] = 1'b1;
        if (tick) m_pend[3] = 1'b1;
    endtask

    task automatic cycle(input bit io, input bit irq, input bit ack, input bit eret);
        invalid_op = io;
        irq_ext    = irq;
        ExcAck     = ack;
        Eret       = eret;
        @(posedge clk);
        model_step(io, irq, ack, eret);
        #1;
        invalid_op = 1'b0;
        irq_ext    = 1'b0;
        ExcAck     = 1'b0;
        Eret       = 1'b0;
    endtask

    task automatic reset_dut();
        invalid_op = 1'b0;
        irq_ext    = 1'b0;
        ExcAck     = 1'b0;
        Eret       = 1'b0;
        reset      = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset_dut();
        vectors++;
        if (obs !== 70'd0) begin
            miscompares++;
            $display("FAIL reset_state: got %h required %h", obs, 70'd0);
        end
    endtask

    task automatic test_invalid_op();
        reset_dut();
        cycle(1, 0, 0, 0);
        vectors++;
        if ({Exc, EStatus, Exc_vector} !== {1'b1, 4'b0001, 64'hD880}) begin
            miscompares++;
            $display("FAIL invop_request: got %h required %h", {Exc, EStatus, Exc_vector}, {1'b1, 4'b0001, 64'hD880});
        end
        for (int i = 0; i < 5; i++) begin
            cycle(0, 0, 0, 0);
            vectors++;
            if (obs !== expected()) begin
                miscompares++;
                $display("FAIL invop_hold%0d: got %h required %h", i, obs, expected());
            end
        end
        cycle(0, 0, 1, 0);
        vectors++;
        if ({Exc, in_handler} !== 2'b01 || obs !== expected()) begin
            miscompares++;
            $display("FAIL invop_ack: got %h required %h", obs, expected());
        end
        cycle(0, 0, 0, 1);
        vectors++;
        if (obs !== expected()) begin
            miscompares++;
            $display("FAIL invop_eret: got %h required %h", obs, expected());
        end
    endtask

    task automatic test_simultaneous();
        reset_dut();
        cycle(1, 1, 0, 0);
        vectors++;
        if (obs !== expected()) begin
            miscompares++;
            $display("FAIL simul_first: got %h required %h", obs, expected());
        end
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 1);
        vectors++;
        if (Exc !== 1'b0 || obs !== expected()) begin
            miscompares++;
            $display("FAIL simul_gap: got %h required %h", obs, expected());
        end
        cycle(0, 0, 0, 0);
        vectors++;
        if ({Exc, EStatus, Exc_vector} !== {1'b1, 4'b0010, 64'hD900} || obs !== expected()) begin
            miscompares++;
            $display("FAIL simul_second: got %h required %h", obs, expected());
        end
    endtask

    task automatic test_handler_irq();
        reset_dut();
        cycle(1, 0, 0, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 1, 0, 0);
        vectors++;
        if (Exc !== 1'b0 || obs !== expected()) begin
            miscompares++;
            $display("FAIL handler_irq_blocked: got %h required %h", obs, expected());
        end
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 1);
        vectors++;
        if (obs !== expected()) begin
            miscompares++;
            $display("FAIL handler_irq_eret: got %h required %h", obs, expected());
        end
        cycle(0, 0, 0, 0);
        vectors++;
        if (obs !== expected()) begin
            miscompares++;
            $display("FAIL handler_irq_rereq: got %h required %h", obs, expected());
        end
    endtask

    task automatic test_ack_race();
        reset_dut();
        cycle(0, 1, 0, 0);
        cycle(0, 1, 1, 0);
        vectors++;
        if (obs !== expected()) begin
            miscompares++;
            $display("FAIL race_ack: got %h required %h", obs, expected());
        end
        cycle(0, 0, 0, 1);
        cycle(0, 0, 0, 0);
        vectors++;
        if ({Exc, EStatus} !== 5'b1_0010 || obs !== expected()) begin
            miscompares++;
            $display("FAIL race_rereq: got %h required %h", obs, expected());
        end
    endtask

    task automatic test_ignored();
        bit [3:0] stim [6];
        stim = '{4'b0010, 4'b0001, 4'b1000, 4'b0001, 4'b0011, 4'b0011};
        reset_dut();
        for (int i = 0; i < 6; i++) begin
            cycle(stim[i][3], stim[i][2], stim[i][1], stim[i][0]);
            vectors++;
            if (obs !== expected()) begin
                miscompares++;
                $display("FAIL ignored_step%0d: got %h required %h", i, obs, expected());
            end
        end
    endtask

    task automatic test_async_reset();
        reset_dut();
        cycle(1, 0, 0, 0);
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        vectors++;
        if (obs !== 70'd0) begin
            miscompares++;
            $display("FAIL async_reset: got %h required %h", obs, 70'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(0, 0, 0, 0);
            vectors++;
            if (obs !== expected()) begin
                miscompares++;
                $display("FAIL post_reset_idle%0d: got %h required %h", i, obs, expected());
            end
        end
    endtask

    task automatic test_random();
        bit io, irq, ack, eret;
        reset_dut();
        for (int i = 0; i < 800; i++) begin
            io   = ($urandom_range(0, 9) == 0);
            irq  = ($urandom_range(0, 6) == 0);
            ack  = ($urandom_range(0, 2) == 0);
            eret = ($urandom_range(0, 3) == 0);
            cycle(io, irq, ack, eret);
            vectors++;
            if (obs !== expected()) begin
                miscompares++;
                $display("FAIL random_cycle%0d: got %h required %h", i, obs, expected());
            end
`ifndef EXC_TIMER_EN
            vectors++;
            if (EStatus === 4'b0011) begin
                miscompares++;
                $display("FAIL random_no_timer%0d: got %h required not 3", i, EStatus);
            end
`endif
        end
    endtask

`ifdef EXC_TIMER_EN
    task automatic test_timer();
        reset_dut();
        for (int i = 0; i < 60; i++) begin
            cycle(0, 0, (i % 7) == 3, (i > 30) && ((i % 5) == 0));
            vectors++;
            if (obs !== expected()) begin
                miscompares++;
                $display("FAIL timer_cycle%0d: got %h required %h", i, obs, expected());
            end
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_invalid_op();
        test_simultaneous();
        test_handler_irq();
        test_ack_race();
        test_ignored();
        test_async_reset();
`ifdef EXC_TIMER_EN
        test_timer();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
